uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one tx unit (2..8).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, meaning the maximum number of cycles to wait for busy to rise after act.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  NREQ  per-requester send request, level.
REQ-006 SHALL have port req_data  input  NREQ*8  byte of requester i in bits [8i+7:8i].
REQ-007 SHALL have port gnt  output  NREQ  one-hot, 1-cycle pulse; the byte of requester i was accepted.
REQ-008 SHALL have port done  output  NREQ  one-hot, 1-cycle pulse; the byte of requester i finished transmitting.
REQ-009 SHALL have port act  output  1  start pulse to the tx unit.
REQ-010 SHALL have port tx_data  output  8  byte to the tx unit.
REQ-011 SHALL have port busy  input  1  tx unit transmitting.
REQ-012 SHALL have port err  output  1  1-cycle pulse when busy fails to rise within ACK_TIMEOUT.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT_HI and WAIT_LO.
REQ-014 IDLE: at an edge with |req=1 and busy=0, SHALL select the winner w by round-robin; after that edge act=1, gnt[w]=1, tx_data=req_data[w], owner=w, and the state is WAIT_HI.
REQ-015 act and gnt SHALL be exactly one cycle wide and SHALL be 0 in every state other than the grant cycle.
REQ-016 Round-robin SHALL search indices last+1, last+2, ... modulo NREQ, where last is the most recent winner; last SHALL update only on a grant.
REQ-017 IDLE with busy=1 SHALL NOT grant, regardless of req.
REQ-018 tx_data SHALL hold its value from the grant until the next grant.
REQ-019 WAIT_HI: the timeout counter SHALL clear on entry and increment each cycle; busy=1 SHALL cause a transition to WAIT_LO.
REQ-020 WAIT_HI: if the count reaches ACK_TIMEOUT with busy=0, err SHALL pulse for one cycle, the FSM SHALL return to IDLE, and done SHALL NOT pulse.
REQ-021 WAIT_LO: busy=0 SHALL pulse done[owner] for one cycle and return to IDLE; a new grant SHALL be possible at the next edge (no dead cycle beyond the done cycle).
REQ-022 A requester SHALL hold req and req_data stable until it receives gnt; req still high in the cycle after gnt SHALL be treated as a new request.
REQ-023 req dropped before gnt SHALL be treated as withdrawn, with no side effect.
REQ-024 A req that rises while the FSM is not in IDLE SHALL be considered at the next IDLE evaluation only.
REQ-025 The timeout counter SHALL be sized to hold ACK_TIMEOUT and SHALL NOT wrap.
REQ-026 Worst-case wait for any continuously asserting requester SHALL be NREQ-1 transmissions.

Reset
REQ-027 rst=1 SHALL asynchronously force state=IDLE, act=0, gnt=0, done=0, err=0, tx_data=8'h00, counter=0, and last=NREQ-1, so that index 0 has first priority.
REQ-028 Reset mid-transmission SHALL abandon the owner without a done pulse; after release, arbitration SHALL restart from index 0.
REQ-029 The first grant SHALL be possible at the first clock edge after rst deasserts.

Structure
REQ-030 The package uart_pkg SHALL hold the FSM state enum (IDLE, WAIT_HI, WAIT_LO) and the default constants NREQ_DEF=4 and ACK_TIMEOUT_DEF=15.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: req, last; output: one-hot winner and valid), instantiated once.
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 The bench SHALL instantiate uart_tx_arb, tx and echo, with tx_data/act/busy connected between the arbiter and tx, and a 10 ns clock.
REQ-034 Single request: req=4'b0010, req_data[15:8]=8'h96 -> one act pulse, gnt=4'b0010, tx_data=8'h96; the echo returns 8'h96 with err=0; done[1] pulses after busy falls.
REQ-035 Contention: req=4'b1111 held, each dropped after its gnt -> grant order 0,1,2,3; exactly one act per byte; no act while busy=1.
REQ-036 Fairness: req[0] and req[2] kept high for 6 transmissions -> grants alternate 0,2,0,2,0,2.
REQ-037 Timeout: busy tied 0, req=4'b0001 -> act pulse, then err pulses exactly ACK_TIMEOUT cycles later, no done, and the FSM returns to IDLE and re-grants.
REQ-038 Reset mid-frame: assert rst while in WAIT_LO with owner=2 -> outputs go 0 immediately; after release with req=4'b0101, the first grant is index 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_e;

    localparam int NREQ_DEF        = 4;
    localparam int ACK_TIMEOUT_DEF = 15;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NREQ.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int LW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic            vld
);

    always_comb begin
        win = '0;
        vld = 1'b0;
        // Distance k from the previous winner; the nearest requester wins.
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!vld && req[i] && (((int'(last) + k) % NREQ) == i)) begin
                    win[i] = 1'b1;
                    vld    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter among NREQ byte requesters with round-robin arbitration
// and a busy-handshake watchdog.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              act,
    output logic [7:0]        tx_data,
    input  logic              busy,
    output logic              err
);

    localparam int LW = $clog2(NREQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   last_q, last_d;
    logic [LW-1:0]   owner_q, owner_d;
    logic            act_q, act_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic [NREQ-1:0] win;
    logic            win_vld;
    logic [LW-1:0]   win_idx;
    logic [7:0]      win_byte;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req),
        .last (last_q),
        .win  (win),
        .vld  (win_vld)
    );

    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx  = LW'(i);
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        act_d     = 1'b0;
        gnt_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        tx_data_d = tx_data_q;

        case (state_q)
            IDLE: begin
                if (win_vld && !busy) begin
                    act_d     = 1'b1;
                    gnt_d     = win;
                    tx_data_d = win_byte;
                    owner_d   = win_idx;
                    last_d    = win_idx;
                    cnt_d     = '0;
                    state_d   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_LO;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    // Count would reach ACK_TIMEOUT: give up on this byte, no done.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!busy) begin
                    for (int i = 0; i < NREQ; i++) begin
                        done_d[i] = (LW'(i) == owner_q);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= LW'(NREQ - 1);
            owner_q   <= '0;
            act_q     <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            act_q     <= act_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign act     = act_q;
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign tx_data = tx_data_q;

endmodule
